timer_digit_formatter: RTL and testbench
========================================

TIMER_DIGIT_FORMATTER -- requirements
Module: timer_digit_formatter

Interface
REQ-001 SHALL have ports: clk  in  1  single system clock; all state updates on rising edge.
REQ-002 SHALL have ports: reset  in  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-003 SHALL have ports: timer_val  in  13  remaining game time in 60 Hz frames, unsigned, from the gameover timer.
REQ-004 SHALL have ports: refresh  in  1  single-cycle request to reconvert even if timer_val is unchanged.
REQ-005 SHALL have ports: min_bcd  out  4  minutes digit, BCD, range 0-2.
REQ-006 SHALL have ports: sec_tens  out  4  seconds tens digit, BCD, range 0-5.
REQ-007 SHALL have ports: sec_ones  out  4  seconds ones digit, BCD, range 0-9.
REQ-008 SHALL have ports: digits_valid  out  1  one-cycle pulse when the digit outputs take a new result.
REQ-009 SHALL have ports: busy  out  1  high while a conversion is in progress.
REQ-010 SHALL have ports: low_time  out  1  high when displayed total seconds is 1..10.
REQ-011 SHALL have ports: expired  out  1  high when displayed total seconds is 0.

Function
REQ-012 SHALL convert frames to whole seconds rounded up: S = floor((timer_val+59)/60), computed in a 14-bit accumulator with no overflow (max 8250).
REQ-013 SHALL display S as M:TU, where M = floor(S/60), T = floor((S mod 60)/10), U = S mod 10. The display range is 0:00-2:17.
REQ-014 SHALL implement FSM states IDLE, FRM, MIN, TEN, DONE, using only repeated subtraction (no divider or multiplier).
REQ-015 IDLE: when pending flag set, or timer_val != last_val, or refresh=1, SHALL latch acc=timer_val+59 and last_val=timer_val, clear pending, clear counters, and go to FRM. busy=1 from the next cycle.
REQ-016 FRM: each cycle, if acc>=60 SHALL do acc-=60 and sec++; else SHALL go to MIN.
REQ-017 MIN: each cycle, if sec>=60 SHALL do sec-=60 and min++; else SHALL go to TEN.
REQ-018 TEN: each cycle, if sec>=10 SHALL do sec-=10 and tens++; else SHALL go to DONE.
REQ-019 DONE (one cycle): SHALL register min_bcd, sec_tens, sec_ones (ones=sec remainder), low_time, expired; pulse digits_valid=1; then return to IDLE with busy=0.
REQ-020 Latency SHALL be exactly q+m+t+4 clock edges from the IDLE capture edge to the edge registering the outputs, where q=S, m=M, t=T.
REQ-021 Digit, low_time and expired outputs SHALL hold their value between DONE cycles. Intermediate values SHALL never appear on the outputs.
REQ-022 Changes of timer_val or refresh while busy SHALL NOT abort the conversion. A refresh pulse while busy SHALL set pending. Afterwards IDLE SHALL reconvert using the timer_val present at that IDLE cycle.
REQ-023 IDLE SHALL capture in the same cycle as an arrival. The back-to-back gap between DONE and the next capture SHALL be exactly one IDLE cycle.
REQ-024 Counters SHALL be sized so that 8191 input converts without wrap: sec 8 bits, min and tens 4 bits.

Reset
REQ-025 On reset SHALL set: min_bcd=0, sec_tens=0, sec_ones=0, digits_valid=0, busy=0, low_time=0, expired=0, last_val=0, state=IDLE, pending=1.
REQ-026 Reset asserted mid-conversion SHALL abandon it immediately with no digits_valid pulse. The first cycle after reset release SHALL capture timer_val (pending=1) regardless of its value.

Verification
REQ-027 Reset, then hold timer_val=8191: outputs 2:17 (2,1,7), low_time=0, expired=0, digits_valid single pulse 144 edges after capture, busy low afterwards.
REQ-028 Hold timer_val=0 after reset: 0:00, expired=1, low_time=0, latency 4 edges. Then timer_val=1: 0:01, low_time=1, expired=0, latency 5.
REQ-029 Boundaries: timer_val=600 -> 0:10, low_time=1. timer_val=601 -> 0:11, low_time=0. timer_val=3600 -> 1:00. timer_val=3599 -> 1:00. timer_val=3540 -> 0:59.
REQ-030 Convert 8191, then change timer_val to 3600 at cycle 20 of busy: first result 2:17 with one pulse, one IDLE cycle, then 1:00 with a second pulse. Outputs never show other values.
REQ-031 Stable timer_val=1234, no refresh: no further conversion or pulse. refresh pulse -> reconversion to 0:21, one pulse. refresh while busy -> exactly one extra conversion.
REQ-032 Assert reset at cycle 50 of an 8191 conversion: all outputs 0 next edge, no pulse. After release, fresh conversion yields 2:17.

Source files
------------

// File: rtl/timer_digit_formatter.sv
// Converts a 60 Hz frame countdown into M:TU display digits by repeated
// subtraction, with low-time and expired flags derived from the result.
module timer_digit_formatter (
    input  logic        clk,
    input  logic        reset,
    input  logic [12:0] timer_val,
    input  logic        refresh,
    output logic [3:0]  min_bcd,
    output logic [3:0]  sec_tens,
    output logic [3:0]  sec_ones,
    output logic        digits_valid,
    output logic        busy,
    output logic        low_time,
    output logic        expired
);

    localparam int unsigned TV_W  = 13;
    localparam int unsigned ACC_W = 14;
    localparam int unsigned SEC_W = 8;
    localparam int unsigned CNT_W = 4;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_FRM  = 3'd1;
    localparam logic [2:0] ST_MIN  = 3'd2;
    localparam logic [2:0] ST_TEN  = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    logic [2:0]       state_q,   state_d;
    logic [ACC_W-1:0] acc_q,     acc_d;
    logic [SEC_W-1:0] sec_q,     sec_d;
    logic [CNT_W-1:0] min_q,     min_d;
    logic [CNT_W-1:0] tens_q,    tens_d;
    logic [TV_W-1:0]  last_q,    last_d;
    logic             pending_q, pending_d;

    logic [3:0] min_bcd_d, sec_tens_d, sec_ones_d;
    logic       digits_valid_d, busy_d, low_time_d, expired_d;

    // State, working registers and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            acc_q        <= '0;
            sec_q        <= '0;
            min_q        <= '0;
            tens_q       <= '0;
            last_q       <= '0;
            pending_q    <= 1'b1;
            min_bcd      <= '0;
            sec_tens     <= '0;
            sec_ones     <= '0;
            digits_valid <= 1'b0;
            busy         <= 1'b0;
            low_time     <= 1'b0;
            expired      <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            sec_q        <= sec_d;
            min_q        <= min_d;
            tens_q       <= tens_d;
            last_q       <= last_d;
            pending_q    <= pending_d;
            min_bcd      <= min_bcd_d;
            sec_tens     <= sec_tens_d;
            sec_ones     <= sec_ones_d;
            digits_valid <= digits_valid_d;
            busy         <= busy_d;
            low_time     <= low_time_d;
            expired      <= expired_d;
        end
    end

    // Next-state and datapath: frames->seconds, seconds->minutes, seconds->tens.
    always_comb begin
        state_d        = state_q;
        acc_d          = acc_q;
        sec_d          = sec_q;
        min_d          = min_q;
        tens_d         = tens_q;
        last_d         = last_q;
        pending_d      = pending_q;
        min_bcd_d      = min_bcd;
        sec_tens_d     = sec_tens;
        sec_ones_d     = sec_ones;
        digits_valid_d = 1'b0;
        busy_d         = busy;
        low_time_d     = low_time;
        expired_d      = expired;

        // A refresh that arrives mid-conversion is remembered for the next IDLE.
        if (refresh && (state_q != ST_IDLE)) begin
            pending_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (pending_q || (timer_val != last_q) || refresh) begin
                    acc_d     = ACC_W'(timer_val) + ACC_W'(59);
                    last_d    = timer_val;
                    pending_d = 1'b0;
                    sec_d     = '0;
                    min_d     = '0;
                    tens_d    = '0;
                    busy_d    = 1'b1;
                    state_d   = ST_FRM;
                end
            end
            ST_FRM: begin
                if (acc_q >= ACC_W'(60)) begin
                    acc_d = acc_q - ACC_W'(60);
                    sec_d = sec_q + SEC_W'(1);
                end else begin
                    state_d = ST_MIN;
                end
            end
            ST_MIN: begin
                if (sec_q >= SEC_W'(60)) begin
                    sec_d = sec_q - SEC_W'(60);
                    min_d = min_q + CNT_W'(1);
                end else begin
                    state_d = ST_TEN;
                end
            end
            ST_TEN: begin
                if (sec_q >= SEC_W'(10)) begin
                    sec_d  = sec_q - SEC_W'(10);
                    tens_d = tens_q + CNT_W'(1);
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                // Flags come from the digits themselves: total 0 is expired, 1..10 is low.
                min_bcd_d      = min_q;
                sec_tens_d     = tens_q;
                sec_ones_d     = sec_q[3:0];
                expired_d      = (min_q == '0) && (tens_q == '0) && (sec_q == '0);
                low_time_d     = (min_q == '0) &&
                                 (((tens_q == '0) && (sec_q != '0)) ||
                                  ((tens_q == CNT_W'(1)) && (sec_q == '0)));
                digits_valid_d = 1'b1;
                busy_d         = 1'b0;
                state_d        = ST_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_timer_digit_formatter.sv
// Scoreboard bench: stimulus pushes hand-computed results, a negedge monitor
// pops and checks them on each digits_valid pulse, plus latency and hold.
module tb_timer_digit_formatter;

    logic        clk = 1'b0;
    logic        reset;
    logic [12:0] timer_val;
    logic        refresh;
    logic [3:0]  min_bcd, sec_tens, sec_ones;
    logic        digits_valid, busy, low_time, expired;

    timer_digit_formatter dut (
        .clk          (clk),
        .reset        (reset),
        .timer_val    (timer_val),
        .refresh      (refresh),
        .min_bcd      (min_bcd),
        .sec_tens     (sec_tens),
        .sec_ones     (sec_ones),
        .digits_valid (digits_valid),
        .busy         (busy),
        .low_time     (low_time),
        .expired      (expired)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] m;
        logic [3:0] t;
        logic [3:0] u;
        logic       low;
        logic       ex;
        int         lat;
        bit         b2b;
    } exp_t;

    exp_t        sb[$];
    exp_t        cur;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          busy_cnt = 0;
    bit          chk_b2b = 1'b0;
    logic [13:0] shown = '0;

    function automatic void check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
        end
    endfunction

    task automatic push(input int m, input int t, input int u, input int low,
                        input int ex, input int lat, input bit b2b);
        exp_t e;
        e.m   = 4'(m);
        e.t   = 4'(t);
        e.u   = 4'(u);
        e.low = 1'(low);
        e.ex  = 1'(ex);
        e.lat = lat;
        e.b2b = b2b;
        sb.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain(input int lim);
        for (int i = 0; i < lim && sb.size() != 0; i++) tick(1);
        check("drain_queue_empty", sb.size(), 0);
        sb.delete();
        tick(2);
        check("busy_low_after", int'(busy), 0);
    endtask

    task automatic wait_busy(input int lim);
        for (int i = 0; i < lim && !busy; i++) tick(1);
        check("busy_rise", int'(busy), 1);
    endtask

    // Monitor: pops on each pulse, checks digits/flags/latency, and otherwise
    // checks that the outputs hold the last announced result.
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                busy_cnt = 0;
                shown    = '0;
                chk_b2b  = 1'b0;
            end else begin
                if (chk_b2b) begin
                    check("b2b_one_idle_gap", int'(busy), 1);
                    chk_b2b = 1'b0;
                end
                if (busy) busy_cnt++;
                if (digits_valid) begin
                    if (sb.size() == 0) begin
                        check("unexpected_pulse", 1, 0);
                    end else begin
                        cur = sb.pop_front();
                        check("min_bcd",  int'(min_bcd),  int'(cur.m));
                        check("sec_tens", int'(sec_tens), int'(cur.t));
                        check("sec_ones", int'(sec_ones), int'(cur.u));
                        check("low_time", int'(low_time), int'(cur.low));
                        check("expired",  int'(expired),  int'(cur.ex));
                        check("latency",  busy_cnt,       cur.lat);
                        check("busy_at_pulse", int'(busy), 0);
                        shown   = {cur.m, cur.t, cur.u, cur.low, cur.ex};
                        chk_b2b = cur.b2b;
                    end
                    busy_cnt = 0;
                end else begin
                    check("outputs_hold",
                          int'({min_bcd, sec_tens, sec_ones, low_time, expired}),
                          int'(shown));
                end
            end
        end
    end

    initial begin
        reset     = 1'b1;
        refresh   = 1'b0;
        timer_val = 13'd8191;
        tick(3);
        check("rst_min_bcd",  int'(min_bcd),      0);
        check("rst_sec_tens", int'(sec_tens),     0);
        check("rst_sec_ones", int'(sec_ones),     0);
        check("rst_valid",    int'(digits_valid), 0);
        check("rst_busy",     int'(busy),         0);
        check("rst_low",      int'(low_time),     0);
        check("rst_expired",  int'(expired),      0);

        // Max input: 8250/60 = 137 s = 2:17, latency 137+2+1+4.
        push(2, 1, 7, 0, 0, 144, 1'b0);
        reset = 1'b0;
        drain(400);

        // Zero after reset is captured via pending, then one frame.
        reset     = 1'b1;
        timer_val = 13'd0;
        tick(2);
        sb.delete();
        push(0, 0, 0, 0, 1, 4, 1'b0);
        reset = 1'b0;
        drain(50);
        timer_val = 13'd1;
        push(0, 0, 1, 1, 0, 5, 1'b0);
        drain(50);

        // Boundaries of rounding and of the low-time window.
        timer_val = 13'd600;  push(0, 1, 0, 1, 0, 15, 1'b0); drain(100);
        timer_val = 13'd601;  push(0, 1, 1, 0, 0, 16, 1'b0); drain(100);
        timer_val = 13'd3600; push(1, 0, 0, 0, 0, 65, 1'b0); drain(200);
        timer_val = 13'd3599; push(1, 0, 0, 0, 0, 65, 1'b0); drain(200);
        timer_val = 13'd3540; push(0, 5, 9, 0, 0, 68, 1'b0); drain(200);

        // Input changes mid-conversion: finish 2:17, one idle cycle, then 1:00.
        timer_val = 13'd8191;
        push(2, 1, 7, 0, 0, 144, 1'b1);
        push(1, 0, 0, 0, 0, 65, 1'b0);
        wait_busy(5);
        tick(20);
        timer_val = 13'd3600;
        drain(400);

        // Stable input: a single conversion, then silence until refresh.
        timer_val = 13'd1234;
        push(0, 2, 1, 0, 0, 27, 1'b0);
        drain(100);
        tick(20);
        push(0, 2, 1, 0, 0, 27, 1'b0);
        refresh = 1'b1;
        tick(1);
        refresh = 1'b0;
        drain(100);

        // Refresh while busy yields exactly one extra conversion.
        push(0, 2, 1, 0, 0, 27, 1'b1);
        push(0, 2, 1, 0, 0, 27, 1'b0);
        refresh = 1'b1;
        tick(1);
        refresh = 1'b0;
        wait_busy(5);
        tick(5);
        refresh = 1'b1;
        tick(1);
        refresh = 1'b0;
        drain(200);
        tick(30);

        // Reset in the middle of a long conversion abandons it.
        timer_val = 13'd8191;
        push(2, 1, 7, 0, 0, 144, 1'b0);
        wait_busy(5);
        tick(49);
        reset = 1'b1;
        tick(1);
        check("midrst_min_bcd",  int'(min_bcd),      0);
        check("midrst_sec_tens", int'(sec_tens),     0);
        check("midrst_sec_ones", int'(sec_ones),     0);
        check("midrst_valid",    int'(digits_valid), 0);
        check("midrst_busy",     int'(busy),         0);
        check("midrst_low",      int'(low_time),     0);
        check("midrst_expired",  int'(expired),      0);
        sb.delete();
        push(2, 1, 7, 0, 0, 144, 1'b0);
        reset = 1'b0;
        drain(400);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
